// File: rtl/ps2_keyfifo.sv
// Keystroke FIFO between the PS/2 decoder and the CPU bus; dout and irq register one cycle after the access.
// No backpressure to the decoder: a key arriving while full (with no pop) is dropped and sets sticky ovfl.
module ps2_keyfifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       key_valid,
    input  logic [7:0] key_ascii,
    input  logic       caps_lock,
    output logic       irq
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_q, wp_d;
    logic [DEPTH_LOG2-1:0] rp_q, rp_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovfl_q, ovfl_d;
    logic                  irq_en_q, irq_en_d;
    logic                  irq_q, irq_d;
    logic [7:0]            dout_q, dout_d;

    logic empty, full, data_rd, stat_rd, ctrl_wr, flush, pop, push_acc;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        data_rd  = cs & ~we & addr;
        stat_rd  = cs & ~we & ~addr;
        ctrl_wr  = cs & we & ~addr;
        flush    = ctrl_wr & din[0];
        pop      = data_rd & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO can still take the key.
        push_acc = key_valid & (~full | pop) & ~flush;

        wp_d     = wp_q;
        rp_d     = rp_q;
        count_d  = count_q;
        ovfl_d   = ovfl_q;
        irq_en_d = irq_en_q;
        dout_d   = dout_q;
        irq_d    = irq_en_q & ~empty;

        if (push_acc) wp_d = wp_q + 1'b1;
        if (pop)      rp_d = rp_q + 1'b1;

        case ({push_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (key_valid & full & ~pop) ovfl_d = 1'b1;

        if (data_rd) dout_d = pop ? mem_q[rp_q] : 8'h00;
        if (stat_rd) dout_d = {3'b000, irq_en_q, caps_lock, full, ovfl_q, ~empty};

        if (ctrl_wr) irq_en_d = din[1];
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
            ovfl_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            ovfl_q   <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            dout_q   <= 8'h00;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            count_q  <= count_d;
            ovfl_q   <= ovfl_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
            dout_q   <= dout_d;
        end
    end

    // Storage needs no reset; count/pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push_acc) mem_q[wp_q] <= key_ascii;
    end

    assign dout = dout_q;
    assign irq  = irq_q;
endmodule

// File: tb/tb_ps2_keyfifo.sv
// Scoreboard bench for ps2_keyfifo: expected bytes queued at push, compared at data read.
module tb_ps2_keyfifo;
    logic       clk = 1'b0;
    logic       rst, cs, we, addr, key_valid, caps_lock;
    logic [7:0] din, key_ascii, dout;
    logic       irq;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];
    logic [7:0] rd, exp_b;

    ps2_keyfifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din), .dout(dout),
        .key_valid(key_valid), .key_ascii(key_ascii), .caps_lock(caps_lock), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs = 0; we = 0; addr = 0; din = 8'h00; key_valid = 0; key_ascii = 8'h00;
    endtask

    task automatic push_key(input logic [7:0] b, input logic accept);
        key_valid = 1; key_ascii = b;
        if (accept) sb.push_back(b);
        tick();
        key_valid = 0;
    endtask

    task automatic bus_read(input logic a, output logic [7:0] d);
        cs = 1; we = 0; addr = a;
        tick();
        cs = 0;
        d = dout;
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        cs = 1; we = 1; addr = a; din = d;
        tick();
        cs = 0; we = 0; din = 8'h00;
    endtask

    task automatic next_exp(output logic [7:0] e);
        if (sb.size() == 0) e = 8'hxx;
        else e = sb.pop_front();
    endtask

    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        bus_read(0, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_status got=%h exp=00", rd); end
    endtask

    task automatic test_basic();
        push_key(8'h41, 1); push_key(8'h42, 1); push_key(8'h43, 1);
        bus_read(0, rd);
        checks++; if (rd !== 8'h01) begin errors++; $display("FAIL basic_status got=%h exp=01", rd); end
        for (int i = 0; i < 3; i++) begin
            bus_read(1, rd); next_exp(exp_b);
            checks++; if (rd !== exp_b) begin errors++; $display("FAIL basic_data%0d got=%h exp=%h", i, rd, exp_b); end
        end
        bus_read(0, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL basic_status_empty got=%h exp=00", rd); end
        bus_read(1, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL basic_read_empty got=%h exp=00", rd); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) push_key(8'h30 + 8'(i), 1);
        push_key(8'h7A, 0);
        bus_read(0, rd);
        checks++; if (rd !== 8'h07) begin errors++; $display("FAIL ovfl_status got=%h exp=07", rd); end
        for (int i = 0; i < 16; i++) begin
            bus_read(1, rd); next_exp(exp_b);
            checks++; if (rd !== exp_b) begin errors++; $display("FAIL ovfl_data%0d got=%h exp=%h", i, rd, exp_b); end
        end
        bus_read(0, rd);
        checks++; if (rd !== 8'h02) begin errors++; $display("FAIL ovfl_sticky got=%h exp=02", rd); end
        bus_write(0, 8'h01);
        bus_read(0, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL ovfl_flush got=%h exp=00", rd); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push_key(8'h60 + 8'(i), 1);
        cs = 1; we = 0; addr = 1; key_valid = 1; key_ascii = 8'h55;
        tick();
        cs = 0; key_valid = 0;
        next_exp(exp_b); sb.push_back(8'h55);
        checks++; if (dout !== exp_b) begin errors++; $display("FAIL fullpp_head got=%h exp=%h", dout, exp_b); end
        bus_read(0, rd);
        checks++; if (rd !== 8'h05) begin errors++; $display("FAIL fullpp_status got=%h exp=05", rd); end
        for (int i = 0; i < 16; i++) begin
            bus_read(1, rd); next_exp(exp_b);
            checks++; if (rd !== exp_b) begin errors++; $display("FAIL fullpp_data%0d got=%h exp=%h", i, rd, exp_b); end
        end
        bus_read(0, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL fullpp_drained got=%h exp=00", rd); end
    endtask

    task automatic test_irq();
        bus_write(0, 8'h02);
        push_key(8'h0D, 1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", irq); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", irq); end
        bus_read(0, rd);
        checks++; if (rd !== 8'h11) begin errors++; $display("FAIL irq_status got=%h exp=11", rd); end
        bus_read(1, rd); next_exp(exp_b);
        checks++; if (rd !== exp_b) begin errors++; $display("FAIL irq_data got=%h exp=%h", rd, exp_b); end
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got=%b exp=0", irq); end
        bus_write(0, 8'h00);
    endtask

    task automatic test_wrap();
        int bad = 0;
        for (int c = 0; c < 43; c++) begin
            key_valid = (c < 40); key_ascii = 8'(c);
            if (c < 40) sb.push_back(8'(c));
            cs = (c >= 3); we = 0; addr = 1;
            tick();
            key_valid = 0; cs = 0;
            if (c >= 3) begin
                next_exp(exp_b);
                checks++;
                if (dout !== exp_b) begin
                    errors++; bad++;
                    if (bad < 4) $display("FAIL wrap_data%0d got=%h exp=%h", c - 3, dout, exp_b);
                end
            end
        end
        bus_read(0, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL wrap_status got=%h exp=00", rd); end
    endtask

    task automatic test_flush_vs_key();
        push_key(8'hA1, 0); push_key(8'hA2, 0);
        cs = 1; we = 1; addr = 0; din = 8'h01; key_valid = 1; key_ascii = 8'h99;
        tick();
        idle();
        bus_read(0, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL flushkey_status got=%h exp=00", rd); end
        bus_read(1, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL flushkey_data got=%h exp=00", rd); end
    endtask

    task automatic test_caps_reset();
        caps_lock = 1;
        bus_read(0, rd);
        checks++; if (rd !== 8'h08) begin errors++; $display("FAIL caps_status got=%h exp=08", rd); end
        bus_write(0, 8'h02);
        for (int i = 0; i < 5; i++) push_key(8'hC0 + 8'(i), 0);
        bus_read(0, rd);
        checks++; if (rd !== 8'h19) begin errors++; $display("FAIL caps_loaded got=%h exp=19", rd); end
        rst = 1; cs = 1; we = 0; addr = 1; key_valid = 1; key_ascii = 8'hEE;
        tick();
        rst = 0; idle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", irq); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout got=%h exp=00", dout); end
        bus_read(0, rd);
        checks++; if (rd !== 8'h08) begin errors++; $display("FAIL rst_status got=%h exp=08", rd); end
        bus_read(1, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", rd); end
    endtask

    initial begin
        idle(); rst = 1; caps_lock = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_irq();
        test_wrap();
        test_flush_vs_key();
        test_caps_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_keyfifo.md
Name: ps2_keyfifo

Overview:
Keystroke buffer between the PS/2 scan-code decoder and the CPU bus. It accepts one-cycle ASCII strobes from the decoder and holds them in a small circular FIFO, so typeahead is not lost while the CPU is busy. It presents a two-register status/data interface on the system data bus and provides an optional level interrupt when keys are waiting.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries); legal range 2..6

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high; clock clk
cs  in  1  chip select
we  in  1  write enable (1=write, 0=read)
addr  in  1  register select (0=status/control, 1=data)
din  in  8  CPU write data
dout  out  8  CPU read data, registered
key_valid  in  1  one-cycle strobe from the decoder: key_ascii is valid
key_ascii  in  8  decoded ASCII byte
caps_lock  in  1  caps-lock state from the decoder, passed through to status
irq  out  1  interrupt request, active-high level, registered

Behaviour:
- Storage
  - Register array of 2^DEPTH_LOG2 x 8.
  - Write pointer wp and read pointer rp are each DEPTH_LOG2 bits and wrap modulo depth.
  - count is DEPTH_LOG2+1 bits, range 0..depth.
  - empty = (count==0); full = (count==depth).
- Push
  - A push is requested when key_valid=1.
  - It is accepted if !full, or if full and a pop occurs in the same cycle.
  - Accepted push: mem[wp]<=key_ascii; wp<=wp+1.
  - Rejected push (full, no pop): the byte is dropped, the FIFO is unchanged, and ovfl<=1.
- Pop
  - A pop occurs when cs & !we & addr & !empty.
  - On that cycle dout<=mem[rp] (the pre-pop head) and rp<=rp+1.
  - A data read while empty: dout<=8'h00, no pointer change, ovfl unchanged.
- Simultaneous push and pop
  - Both take effect and count is unchanged.
  - This applies in every state, including full (no overflow) and count=1 (the popped byte is the old head; the new byte remains).
- Count update: count <= count + push_acc - pop.
- Status read (cs & !we & !addr)
  - dout <= {3'b000, irq_en, caps_lock, full, ovfl, !empty}.
  - The status read has no side effects.
- Read latency: dout is valid the cycle after cs. dout holds its value when not being read.
- Control write (cs & we & !addr)
  - din[1] -> irq_en, stored.
  - din[0]=1 -> flush: wp<=0, rp<=0, count<=0, ovfl<=0 on that cycle. The flush bit is not stored.
  - Flush coinciding with key_valid: flush wins and the byte is discarded.
- Data writes (cs & we & addr) are ignored.
- ovfl is sticky. It is cleared only by rst or by a flush.
- irq is registered: irq <= irq_en & !empty, so it follows a state change by one cycle.
  - After a pop that empties the FIFO, irq deasserts on the following cycle.
- Reset (sync, rst=1)
  - wp=rp=count=0, ovfl=0, irq_en=0, irq=0, dout=8'h00.
  - Reset mid-stream discards all contents.
  - rst has priority over all bus and key activity.
- No combinational path from cs/we/addr to dout or irq.

Test Plan:
1. Reset, then push 0x41, 0x42, 0x43 on separate cycles -> status read = 0x01; three data reads return 0x41, 0x42, 0x43 in order; next status = 0x00; a fourth data read returns 0x00.
2. Push 16 bytes 0x30..0x3F, then a 17th byte 0x7A -> status = 0x07; the 16 data reads return 0x30..0x3F and 0x7A never appears; status then = 0x02; write 0x01 to addr0 -> status = 0x00.
3. Fill to 16 entries, then assert key_valid=0x55 in the same cycle as a data read -> read returns the oldest byte, ovfl stays 0, count stays 16, and 0x55 is the last byte drained.
4. Write 0x02 (irq_en), push 0x0D -> irq rises 1 cycle after the push; status = 0x11; data read returns 0x0D; irq falls the cycle after the read.
5. Wrap-around: stream 40 bytes 0x00..0x27, reading each byte 3 cycles after its push -> all 40 are returned in order with no ovfl (pointers wrap twice).
6. Set caps_lock=1 -> status bit3 set (0x08 when empty). Assert rst while the FIFO holds 5 bytes -> status = 0x08 (caps bit only), irq=0, dout=0x00.
